// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer result FIFOs feeding a round-robin
// selector that broadcasts one registered result per cycle to the CDB.

module cdb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         ready,
    output logic         nonempty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign ready    = (count < FULL);
    assign nonempty = (count != '0);
    assign rdata    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end
endmodule

module cdb_arbiter #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [31:0]      alu_data,
    input  logic [TAG_W-1:0] alu_tag,
    input  logic             alu_changeFlow,
    input  logic [31:0]      alu_jb_addr,
    input  logic             lsq_valid,
    output logic             lsq_ready,
    input  logic [31:0]      lsq_data,
    input  logic [TAG_W-1:0] lsq_tag,
    output logic             cdb_valid,
    output logic [31:0]      cdb_data,
    output logic [TAG_W-1:0] cdb_tag,
    output logic             cdb_changeFlow,
    output logic [31:0]      cdb_jb_addr,
    output logic             cdb_src
);
    localparam int AW = 32 + TAG_W + 1 + 32;
    localparam int LW = 32 + TAG_W;
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSQ = 1'b1;

    logic          alu_push, alu_pop, alu_nonempty;
    logic          lsq_push, lsq_pop, lsq_nonempty;
    logic [AW-1:0] alu_head;
    logic [LW-1:0] lsq_head;
    logic          grant_alu, grant_lsq;
    logic          last_grant;

    assign alu_push = alu_valid & alu_ready & ~flush;
    assign lsq_push = lsq_valid & lsq_ready & ~flush;

    cdb_fifo #(.W(AW), .DEPTH(DEPTH)) u_alu_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (alu_push),
        .pop      (alu_pop),
        .wdata    ({alu_data, alu_tag, alu_changeFlow, alu_jb_addr}),
        .rdata    (alu_head),
        .ready    (alu_ready),
        .nonempty (alu_nonempty)
    );

    cdb_fifo #(.W(LW), .DEPTH(DEPTH)) u_lsq_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (lsq_push),
        .pop      (lsq_pop),
        .wdata    ({lsq_data, lsq_tag}),
        .rdata    (lsq_head),
        .ready    (lsq_ready),
        .nonempty (lsq_nonempty)
    );

    // On a tie the source that did not win last time goes first.
    assign grant_alu = alu_nonempty & (~lsq_nonempty | (last_grant == SRC_LSQ));
    assign grant_lsq = lsq_nonempty & ~grant_alu;

    assign alu_pop = grant_alu & ~flush;
    assign lsq_pop = grant_lsq & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= SRC_LSQ;
            cdb_valid      <= 1'b0;
            cdb_data       <= '0;
            cdb_tag        <= '0;
            cdb_changeFlow <= 1'b0;
            cdb_jb_addr    <= '0;
            cdb_src        <= 1'b0;
        end else if (flush) begin
            last_grant <= SRC_LSQ;
            cdb_valid  <= 1'b0;
        end else if (grant_alu) begin
            last_grant     <= SRC_ALU;
            cdb_valid      <= 1'b1;
            {cdb_data, cdb_tag, cdb_changeFlow, cdb_jb_addr} <= alu_head;
            cdb_src        <= SRC_ALU;
        end else if (grant_lsq) begin
            last_grant     <= SRC_LSQ;
            cdb_valid      <= 1'b1;
            {cdb_data, cdb_tag} <= lsq_head;
            cdb_changeFlow <= 1'b0;
            cdb_jb_addr    <= '0;
            cdb_src        <= SRC_LSQ;
        end else begin
            cdb_valid <= 1'b0;
        end
    end
endmodule
